hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_ctrl_if.sv | 30 +++
 rtl/hazard_scoreboard.sv | 42 ++++
 rtl/hazard_ctrl.sv | 82 ++++++++
 tb/tb_hazard_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings, FSM states and scoreboard slot type for hazard_ctrl
package hazard_pkg;
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [4:0] XZR = 5'd31;
  typedef enum logic {RUN, MUL_WAIT} state_t;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       load;
  } slot_t;
  localparam slot_t SLOT_NONE = '0;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode-side inputs and pipeline-control outputs of the hazard controller
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic             id_valid;
  logic [4:0]       id_rn;
  logic [4:0]       id_rm;
  logic [4:0]       id_rd;
  logic             id_uses_rn;
  logic             id_uses_rm;
  logic             id_regwrite;
  logic             id_load;
  logic             id_mul;
  logic             ex_br_taken;
  logic             stall_if_id;
  logic             bubble_ex;
  logic             flush;
  logic             ex_hold;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    output id_valid, id_rn, id_rm, id_rd, id_uses_rn, id_uses_rm,
           id_regwrite, id_load, id_mul, ex_br_taken,
    input  stall_if_id, bubble_ex, flush, ex_hold, fwd_a, fwd_b, stall_cycles
  );
  modport slave (
    input  id_valid, id_rn, id_rm, id_rd, id_uses_rn, id_uses_rm,
           id_regwrite, id_load, id_mul, ex_br_taken,
    output stall_if_id, bubble_ex, flush, ex_hold, fwd_a, fwd_b, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: EX/MEM/WB in-flight destination slots and per-operand match against ID
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       issue,
  input  logic       hold,
  input  logic       regwrite,
  input  logic       load,
  input  logic [4:0] rd,
  input  logic [4:0] rn,
  input  logic [4:0] rm,
  input  logic       use_rn,
  input  logic       use_rm,
  output logic       ex_ma,
  output logic       ex_mb,
  output logic       mem_ma,
  output logic       mem_mb,
  output logic       ex_load
);
  slot_t sb [3];
  slot_t entry;
  assign entry = '{valid: issue && regwrite && rd != XZR, rd: rd, load: load};
  // shift EX->MEM->WB each cycle; a hold freezes EX and drops a bubble into MEM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb[0] <= SLOT_NONE;
      sb[1] <= SLOT_NONE;
      sb[2] <= SLOT_NONE;
    end else begin
      sb[2] <= sb[1];
      sb[1] <= hold ? SLOT_NONE : sb[0];
      sb[0] <= hold ? sb[0] : entry;
    end
  end
  assign ex_ma   = sb[0].valid && use_rn && sb[0].rd == rn;
  assign ex_mb   = sb[0].valid && use_rm && sb[0].rd == rm;
  assign mem_ma  = sb[1].valid && use_rn && sb[1].rd == rn;
  assign mem_mb  = sb[1].valid && use_rm && sb[1].rd == rm;
  assign ex_load = sb[0].load;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/RAW stalls, branch flush, MUL hold and forwarding selects (HAZARD_FWD_EN enables forwarding)
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 16
) (
  input logic         clk,
  input logic         reset_n,
  hazard_ctrl_if.slave hz
);
  localparam int MW = $clog2(MUL_CYCLES + 1);
  state_t state, state_nx;
  logic [MW-1:0] cnt, cnt_nx;
  logic ex_ma, ex_mb, mem_ma, mem_mb, ex_load;
  logic raw_hz, mw, br, stall, bubble, issue;
  logic [1:0] fa, fb;
  hazard_scoreboard u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .issue    (issue),
    .hold     (mw),
    .regwrite (hz.id_regwrite),
    .load     (hz.id_load),
    .rd       (hz.id_rd),
    .rn       (hz.id_rn),
    .rm       (hz.id_rm),
    .use_rn   (hz.id_uses_rn),
    .use_rm   (hz.id_uses_rm),
    .ex_ma    (ex_ma),
    .ex_mb    (ex_mb),
    .mem_ma   (mem_ma),
    .mem_mb   (mem_mb),
    .ex_load  (ex_load)
  );
`ifdef HAZARD_FWD_EN
  assign raw_hz = hz.id_valid && ex_load && (ex_ma || ex_mb);
  assign fa = ex_ma ? FWD_EXMEM : mem_ma ? FWD_MEMWB : FWD_REG;
  assign fb = ex_mb ? FWD_EXMEM : mem_mb ? FWD_MEMWB : FWD_REG;
`else
  logic unused_load;
  assign unused_load = ex_load;
  assign raw_hz = hz.id_valid && (ex_ma || ex_mb || mem_ma || mem_mb);
  assign fa = FWD_REG;
  assign fb = FWD_REG;
`endif
  assign mw     = state == MUL_WAIT;
  assign br     = !mw && hz.ex_br_taken;
  assign stall  = mw || (!br && raw_hz);
  assign bubble = !mw && !br && raw_hz;
  assign issue  = hz.id_valid && !stall && !bubble && !br;
  assign hz.stall_if_id = reset_n && stall;
  assign hz.bubble_ex   = reset_n && bubble;
  assign hz.flush       = reset_n && br;
  assign hz.ex_hold     = reset_n && mw;
  assign hz.fwd_a       = reset_n ? fa : FWD_REG;
  assign hz.fwd_b       = reset_n ? fb : FWD_REG;
  // FSM state, MUL hold counter and saturating stall counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= RUN;
      cnt             <= '0;
      hz.stall_cycles <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (stall && !(&hz.stall_cycles)) hz.stall_cycles <= hz.stall_cycles + 1'b1;
    end
  end
  // enter MUL_WAIT on an issuing MUL; leave once the counter has reached zero
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == RUN) begin
      if (issue && hz.id_mul && MUL_CYCLES > 1) begin
        state_nx = MUL_WAIT;
        cnt_nx   = MW'(MUL_CYCLES > 1 ? MUL_CYCLES - 2 : 0);
      end
    end else if (cnt == '0) state_nx = RUN;
    else cnt_nx = cnt - 1'b1;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl (expectations follow HAZARD_FWD_EN)
module tb_hazard_ctrl;
  import hazard_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int exp_sc = 0;
  int sc0;
  hazard_ctrl_if #(.CNT_W(16)) hz ();
  hazard_ctrl #(.MUL_CYCLES(3), .CNT_W(16)) dut (.clk(clk), .reset_n(reset_n), .hz(hz));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic id_set(input logic v, input logic [4:0] rd, rn, rm,
                        input logic un, um, rw, ld, ml, br);
    hz.id_valid = v; hz.id_rd = rd; hz.id_rn = rn; hz.id_rm = rm;
    hz.id_uses_rn = un; hz.id_uses_rm = um; hz.id_regwrite = rw;
    hz.id_load = ld; hz.id_mul = ml; hz.ex_br_taken = br;
  endtask

  task automatic idle();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input string tag, input logic st, bu, fl, eh);
    @(negedge clk);
    chk({tag, ".stall"}, 32'(hz.stall_if_id), 32'(st));
    chk({tag, ".bubble"}, 32'(hz.bubble_ex), 32'(bu));
    chk({tag, ".flush"}, 32'(hz.flush), 32'(fl));
    chk({tag, ".hold"}, 32'(hz.ex_hold), 32'(eh));
    chk({tag, ".cnt"}, 32'(hz.stall_cycles), 32'(exp_sc));
    if (st) exp_sc++;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, ".stall"}, 32'(hz.stall_if_id), 0);
    chk({tag, ".bubble"}, 32'(hz.bubble_ex), 0);
    chk({tag, ".flush"}, 32'(hz.flush), 0);
    chk({tag, ".hold"}, 32'(hz.ex_hold), 0);
    chk({tag, ".fwd"}, 32'({hz.fwd_a, hz.fwd_b}), 0);
    chk({tag, ".cnt"}, 32'(hz.stall_cycles), 0);
  endtask

  initial begin
    id_set(1, 3, 1, 1, 1, 1, 1, 0, 0, 1);
    #2;
    zero_outs("reset");
    step();
    step();
    idle();
    reset_n = 1'b1;
    ctl("post_reset", 0, 0, 0, 0);
    step();
    // ADDS X1,X2,X3 ; SUBS X4,X1,X5
    id_set(1, 1, 2, 3, 1, 1, 1, 0, 0, 0);
    ctl("adds", 0, 0, 0, 0);
    step();
    id_set(1, 4, 1, 5, 1, 1, 1, 0, 0, 0);
`ifdef HAZARD_FWD_EN
    ctl("subs", 0, 0, 0, 0);
    chk("subs.fwd_a", 32'(hz.fwd_a), 32'(FWD_EXMEM));
    chk("subs.fwd_b", 32'(hz.fwd_b), 32'(FWD_REG));
`else
    ctl("subs_s1", 1, 1, 0, 0);
    step();
    ctl("subs_s2", 1, 1, 0, 0);
    step();
    ctl("subs_go", 0, 0, 0, 0);
    chk("subs.fwd_a", 32'(hz.fwd_a), 32'(FWD_REG));
`endif
    step();
    drain();
    // LDUR X1,[X2,#0] ; ADDS X3,X1,X1
    id_set(1, 1, 2, 0, 1, 0, 1, 1, 0, 0);
    ctl("ldur", 0, 0, 0, 0);
    step();
    id_set(1, 3, 1, 1, 1, 1, 1, 0, 0, 0);
    ctl("lu_stall", 1, 1, 0, 0);
    step();
`ifdef HAZARD_FWD_EN
    ctl("lu_go", 0, 0, 0, 0);
    chk("lu.fwd_a", 32'(hz.fwd_a), 32'(FWD_MEMWB));
    chk("lu.fwd_b", 32'(hz.fwd_b), 32'(FWD_MEMWB));
`else
    ctl("lu_stall2", 1, 1, 0, 0);
    step();
    ctl("lu_go", 0, 0, 0, 0);
`endif
    step();
    drain();
    // ADDI X31,X0,#5 ; ADDS X2,X31,X31
    id_set(1, 31, 0, 0, 1, 0, 1, 0, 0, 0);
    ctl("addi_xzr", 0, 0, 0, 0);
    step();
    id_set(1, 2, 31, 31, 1, 1, 1, 0, 0, 0);
    ctl("xzr_use", 0, 0, 0, 0);
    chk("xzr.fwd", 32'({hz.fwd_a, hz.fwd_b}), 0);
    step();
    drain();
    // MUL X1,X2,X3 then an independent ADD X5,X6,X7
    sc0 = exp_sc;
    id_set(1, 1, 2, 3, 1, 1, 1, 0, 1, 0);
    ctl("mul", 0, 0, 0, 0);
    step();
    id_set(1, 5, 6, 7, 1, 1, 1, 0, 0, 0);
    ctl("mul_h1", 1, 0, 0, 1);
    step();
    hz.ex_br_taken = 1'b1;
    ctl("mul_h2", 1, 0, 0, 1);
    step();
    hz.ex_br_taken = 1'b0;
    ctl("mul_done", 0, 0, 0, 0);
    chk("mul.cnt_delta", 32'(hz.stall_cycles), 32'(sc0 + 2));
    step();
    drain();
    // taken branch while ID holds a load-use consumer
    id_set(1, 1, 2, 0, 1, 0, 1, 1, 0, 0);
    ctl("br_ldur", 0, 0, 0, 0);
    step();
    id_set(1, 3, 1, 1, 1, 1, 1, 0, 0, 1);
    ctl("br_flush", 0, 0, 1, 0);
    step();
    id_set(1, 6, 3, 3, 1, 1, 1, 0, 0, 0);
    ctl("br_killed", 0, 0, 0, 0);
    chk("br.fwd", 32'({hz.fwd_a, hz.fwd_b}), 0);
    step();
    drain();
    // reset asserted in the middle of MUL_WAIT
    id_set(1, 1, 2, 3, 1, 1, 1, 0, 1, 0);
    step();
    id_set(1, 4, 1, 1, 1, 1, 1, 0, 0, 1);
    ctl("rst_mw", 1, 0, 0, 1);
    #1 reset_n = 1'b0;
    #1;
    zero_outs("rst_async");
    exp_sc = 0;
    step();
    reset_n = 1'b1;
    hz.ex_br_taken = 1'b0;
    ctl("rst_run", 0, 0, 0, 0);
    chk("rst.fwd", 32'({hz.fwd_a, hz.fwd_b}), 0);
    step();
    idle();
    ctl("rst_after", 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
